// File: rtl/alu_issue_ctrl.sv
// Single-issue controller between an instruction source, a combinational vector ALU
// and a writeback port: accepts one R-type instruction, waits out its latency, then holds the result.
module alu_issue_ctrl #(
  parameter int LONG_LAT  = 4,
  parameter int SHORT_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [0:31] instr,
  output logic        instr_ready,
  input  logic [0:63] rA_data,
  input  logic [0:63] rB_data,
  output logic [0:63] alu_rA,
  output logic [0:63] alu_rB,
  output logic [0:5]  alu_R_ins,
  output logic [0:5]  alu_Op_code,
  output logic [0:1]  alu_WW,
  input  logic [0:63] alu_out,
  output logic        wb_valid,
  output logic [0:4]  wb_addr,
  output logic [0:2]  wb_ppp,
  output logic [0:63] wb_data,
  input  logic        wb_ready,
  output logic        illegal,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // instr_ready is 1 only in IDLE, and wb_valid, once raised, holds with its payload until wb_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int CW = 8;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic        instr_ready_q;
  logic        wb_valid_q;
  logic        illegal_q;
  logic [0:63] alu_rA_q;
  logic [0:63] alu_rB_q;
  logic [0:5]  alu_R_ins_q;
  logic [0:5]  alu_Op_code_q;
  logic [0:1]  alu_WW_q;
  logic [0:4]  wb_addr_q;
  logic [0:2]  wb_ppp_q;
  logic [0:63] wb_data_q;

  logic [0:5] op_d;
  logic [0:5] func_d;
  logic       legal_d;
  logic       long_d;
  logic       unused_fields;

  assign op_d    = instr[0:5];
  assign func_d  = instr[26:31];
  assign legal_d = (op_d == 6'b101010) && (func_d >= 6'b000001) && (func_d <= 6'b010010);
  // VDIV, VMOD and VSQRT are the multi-cycle functions.
  assign long_d  = (func_d == 6'b001110) || (func_d == 6'b001111) || (func_d == 6'b010010);
  // Register specifiers arrive pre-read on rA_data/rB_data, so the rA/rB fields are not needed.
  assign unused_fields = ^instr[11:20];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      instr_ready_q <= 1'b1;
      wb_valid_q    <= 1'b0;
      illegal_q     <= 1'b0;
      alu_rA_q      <= '0;
      alu_rB_q      <= '0;
      alu_R_ins_q   <= '0;
      alu_Op_code_q <= '0;
      alu_WW_q      <= '0;
      wb_addr_q     <= '0;
      wb_ppp_q      <= '0;
      wb_data_q     <= '0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            if (legal_d) begin
              alu_rA_q      <= rA_data;
              alu_rB_q      <= rB_data;
              alu_R_ins_q   <= func_d;
              alu_Op_code_q <= op_d;
              alu_WW_q      <= instr[24:25];
              wb_addr_q     <= instr[6:10];
              wb_ppp_q      <= instr[21:23];
              cnt_q         <= long_d ? CW'(LONG_LAT - 1) : CW'(SHORT_LAT - 1);
              instr_ready_q <= 1'b0;
              state_q       <= EXEC;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            wb_data_q  <= alu_out;
            wb_valid_q <= 1'b1;
            state_q    <= WB;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid_q    <= 1'b0;
            instr_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          wb_valid_q    <= 1'b0;
          instr_ready_q <= 1'b1;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = instr_ready_q;
  assign wb_valid    = wb_valid_q;
  assign illegal     = illegal_q;
  assign alu_rA      = alu_rA_q;
  assign alu_rB      = alu_rB_q;
  assign alu_R_ins   = alu_R_ins_q;
  assign alu_Op_code = alu_Op_code_q;
  assign alu_WW      = alu_WW_q;
  assign wb_addr     = wb_addr_q;
  assign wb_ppp      = wb_ppp_q;
  assign wb_data     = wb_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a small ALU model feeds alu_out and each
// expected value is a hand-computed constant.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [0:31] instr;
  logic        instr_ready;
  logic [0:63] rA_data;
  logic [0:63] rB_data;
  logic [0:63] alu_rA;
  logic [0:63] alu_rB;
  logic [0:5]  alu_R_ins;
  logic [0:5]  alu_Op_code;
  logic [0:1]  alu_WW;
  logic [0:63] alu_out;
  logic        wb_valid;
  logic [0:4]  wb_addr;
  logic [0:2]  wb_ppp;
  logic [0:63] wb_data;
  logic        wb_ready;
  logic        illegal;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [5:0] OP_R   = 6'b101010;
  localparam logic [5:0] F_VAND = 6'b000001;
  localparam logic [5:0] F_VADD = 6'b000100;
  localparam logic [5:0] F_VDIV = 6'b001110;
  localparam logic [5:0] F_VSQR = 6'b010010;

  alu_issue_ctrl #(.LONG_LAT(4), .SHORT_LAT(1)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rA_data(rA_data), .rB_data(rB_data),
    .alu_rA(alu_rA), .alu_rB(alu_rB), .alu_R_ins(alu_R_ins),
    .alu_Op_code(alu_Op_code), .alu_WW(alu_WW), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ppp(wb_ppp), .wb_data(wb_data),
    .wb_ready(wb_ready), .illegal(illegal), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU stand-in: AND, DIV, everything else ADD
  always_comb begin
    case (alu_R_ins)
      6'd1:    alu_out = alu_rA & alu_rB;
      6'd14:   alu_out = (alu_rB == 64'd0) ? 64'd0 : alu_rA / alu_rB;
      default: alu_out = alu_rA + alu_rB;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_instr(input logic [5:0] op, input logic [4:0] rd, input logic [2:0] ppp,
                             input logic [1:0] ww, input logic [5:0] func,
                             input logic [63:0] a, input logic [63:0] b);
    instr_valid = 1'b1;
    instr       = {op, rd, 5'd15, 5'd14, ppp, ww, func};
    rA_data     = a;
    rB_data     = b;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(instr_ready), 64'd1);
    check({tag, "_wbv"}, 64'(wb_valid), 64'd0);
    check({tag, "_ill"}, 64'(illegal), 64'd0);
    check({tag, "_rA"}, alu_rA, 64'd0);
    check({tag, "_rB"}, alu_rB, 64'd0);
    check({tag, "_rins"}, 64'(alu_R_ins), 64'd0);
    check({tag, "_op"}, 64'(alu_Op_code), 64'd0);
    check({tag, "_ww"}, 64'(alu_WW), 64'd0);
    check({tag, "_addr"}, 64'(wb_addr), 64'd0);
    check({tag, "_ppp"}, 64'(wb_ppp), 64'd0);
    check({tag, "_data"}, wb_data, 64'd0);
    check({tag, "_st"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    reset = 1'b0; instr_valid = 1'b0; instr = '0; rA_data = '0; rB_data = '0; wb_ready = 1'b1;
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // VAND rD=3 WW=10, short latency
    @(negedge clk);
    drive_instr(OP_R, 5'd3, 3'b101, 2'b10, F_VAND, 64'd15, 64'd14);
    @(negedge clk);
    instr_valid = 1'b0;
    check("vand_rins", 64'(alu_R_ins), 64'd1);
    check("vand_op", 64'(alu_Op_code), 64'h2a);
    check("vand_ww", 64'(alu_WW), 64'd2);
    check("vand_rA", alu_rA, 64'd15);
    check("vand_rB", alu_rB, 64'd14);
    check("vand_exec_ready", 64'(instr_ready), 64'd0);
    check("vand_exec_wbv", 64'(wb_valid), 64'd0);
    check("vand_exec_st", 64'(dbg_state), 64'd1);
    @(negedge clk);
    check("vand_wbv", 64'(wb_valid), 64'd1);
    check("vand_addr", 64'(wb_addr), 64'd3);
    check("vand_ppp", 64'(wb_ppp), 64'd5);
    check("vand_data", wb_data, 64'd14);
    @(negedge clk);
    check("vand_done_wbv", 64'(wb_valid), 64'd0);
    check("vand_done_ready", 64'(instr_ready), 64'd1);

    // VDIV long latency, instr_valid held high throughout
    drive_instr(OP_R, 5'd0, 3'b010, 2'b00, F_VDIV, 64'd100, 64'd7);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("vdiv_wbv_%0d", i), 64'(wb_valid), 64'd0);
      check($sformatf("vdiv_ready_%0d", i), 64'(instr_ready), 64'd0);
    end
    @(negedge clk);
    check("vdiv_wbv_5", 64'(wb_valid), 64'd1);
    check("vdiv_data", wb_data, 64'd14);
    check("vdiv_addr_r0", 64'(wb_addr), 64'd0);
    instr_valid = 1'b0;
    @(negedge clk);
    check("vdiv_done_ready", 64'(instr_ready), 64'd1);
    check("vdiv_done_wbv", 64'(wb_valid), 64'd0);
    @(negedge clk);
    check("vdiv_no_2nd_st", 64'(dbg_state), 64'd0);

    // illegal opcode, then out-of-range func
    drive_instr(6'b000000, 5'd9, 3'b111, 2'b11, F_VAND, 64'd1, 64'd2);
    @(negedge clk);
    instr_valid = 1'b0;
    check("ill_op_pulse", 64'(illegal), 64'd1);
    check("ill_op_ready", 64'(instr_ready), 64'd1);
    check("ill_op_wbv", 64'(wb_valid), 64'd0);
    check("ill_op_rA", alu_rA, 64'd100);
    check("ill_op_rins", 64'(alu_R_ins), 64'd14);
    @(negedge clk);
    check("ill_op_pulse_end", 64'(illegal), 64'd0);
    drive_instr(OP_R, 5'd9, 3'b111, 2'b11, 6'b010011, 64'd1, 64'd2);
    @(negedge clk);
    instr_valid = 1'b0;
    check("ill_fn_pulse", 64'(illegal), 64'd1);
    check("ill_fn_ready", 64'(instr_ready), 64'd1);
    check("ill_fn_rB", alu_rB, 64'd7);
    check("ill_fn_ww", 64'(alu_WW), 64'd0);
    @(negedge clk);
    check("ill_fn_pulse_end", 64'(illegal), 64'd0);
    check("ill_fn_wbv", 64'(wb_valid), 64'd0);

    // writeback back-pressure for 6 cycles
    wb_ready = 1'b0;
    drive_instr(OP_R, 5'd21, 3'b001, 2'b01, F_VADD, 64'd20, 64'd22);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("bp_wbv_%0d", i), 64'(wb_valid), 64'd1);
      check($sformatf("bp_data_%0d", i), wb_data, 64'd42);
      check($sformatf("bp_addr_%0d", i), 64'(wb_addr), 64'd21);
    end
    @(negedge clk);
    check("bp_wbv_7", 64'(wb_valid), 64'd1);
    wb_ready = 1'b1;
    @(negedge clk);
    check("bp_done_ready", 64'(instr_ready), 64'd1);
    check("bp_done_wbv", 64'(wb_valid), 64'd0);
    drive_instr(OP_R, 5'd4, 3'b000, 2'b00, F_VAND, 64'hf0, 64'h3c);
    @(negedge clk);
    instr_valid = 1'b0;
    check("bp_next_ready", 64'(instr_ready), 64'd0);
    check("bp_next_rins", 64'(alu_R_ins), 64'd1);
    @(negedge clk);
    check("bp_next_data", wb_data, 64'h30);
    @(negedge clk);

    // reset during VSQRT execution
    drive_instr(OP_R, 5'd7, 3'b110, 2'b11, F_VSQR, 64'd81, 64'd3);
    @(negedge clk);
    instr_valid = 1'b0;
    check("sqrt_exec_st", 64'(dbg_state), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_wbv_%0d", i), 64'(wb_valid), 64'd0);
    end
    drive_instr(OP_R, 5'd2, 3'b011, 2'b00, F_VADD, 64'd5, 64'd10);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("vadd_wbv", 64'(wb_valid), 64'd1);
    check("vadd_data", wb_data, 64'd15);
    check("vadd_addr", 64'(wb_addr), 64'd2);
    @(negedge clk);
    check("vadd_done_ready", 64'(instr_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
